// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup for the IF PC, one-cycle training from EX resolutions.

module bp_entry #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [31:0]      wr_target,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [31:0]      target_o,
    output logic [1:0]       cnt_o
);
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      target_q, target_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             hit;

    assign hit = valid_q && (tag_q == wr_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            if (hit) begin
                if (wr_taken) begin
                    target_d = wr_target;
                    if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end
            end else if (wr_taken) begin
                // A not-taken miss leaves the resident (aliasing) entry alone.
                valid_d  = 1'b1;
                tag_d    = wr_tag;
                target_d = wr_target;
                cnt_d    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            tag_q    <= '0;
            target_q <= '0;
            cnt_q    <= 2'd1;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o  = valid_q;
    assign tag_o    = tag_q;
    assign target_o = target_q;
    assign cnt_o    = cnt_q;
endmodule

module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] if_pc,
    output logic        pred_jmp_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pre_fail,
    output logic [31:0] br_total_o,
    output logic [31:0] br_miss_o
);
    localparam int NUM_ENT = 1 << IDX_W;

    logic [NUM_ENT-1:0]            ent_valid;
    logic [NUM_ENT-1:0][TAG_W-1:0] ent_tag;
    logic [NUM_ENT-1:0][31:0]      ent_target;
    logic [NUM_ENT-1:0][1:0]       ent_cnt;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             upd;
    logic             if_hit;
    logic [31:0]      br_total_q, br_total_d;
    logic [31:0]      br_miss_q, br_miss_d;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd    = rdy && ex_br_valid;

    generate
        for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
            bp_entry #(.TAG_W(TAG_W)) u_ent (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (upd && (ex_idx == IDX_W'(i))),
                .wr_tag    (ex_tag),
                .wr_taken  (ex_taken),
                .wr_target (ex_target),
                .valid_o   (ent_valid[i]),
                .tag_o     (ent_tag[i]),
                .target_o  (ent_target[i]),
                .cnt_o     (ent_cnt[i])
            );
        end
    endgenerate

    // Reads registered state only, so a same-cycle write to this index is not seen.
    always_comb begin
        if_hit        = ent_valid[if_idx] && (ent_tag[if_idx] == if_tag);
        pred_jmp_o    = if_hit && ent_cnt[if_idx][1];
        pred_target_o = pred_jmp_o ? ent_target[if_idx] : 32'h0;
    end

    always_comb begin
        br_total_d = br_total_q;
        br_miss_d  = br_miss_q;
        if (upd && (br_total_q != 32'hFFFF_FFFF)) br_total_d = br_total_q + 32'd1;
        if (upd && ex_pre_fail && (br_miss_q != 32'hFFFF_FFFF)) br_miss_d = br_miss_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            br_total_q <= '0;
            br_miss_q  <= '0;
        end else begin
            br_total_q <= br_total_d;
            br_miss_q  <= br_miss_d;
        end
    end

    assign br_total_o = br_total_q;
    assign br_miss_o  = br_miss_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+TAG_W+2], if_pc[1:0],
                              ex_pc[31:IDX_W+TAG_W+2], ex_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: array-based reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.

module tb_branch_predictor;
    logic        clk, rst, rdy;
    logic [31:0] if_pc;
    logic        pred_jmp_o;
    logic [31:0] pred_target_o;
    logic        ex_br_valid, ex_taken, ex_pre_fail;
    logic [31:0] ex_pc, ex_target;
    logic [31:0] br_total_o, br_miss_o;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .if_pc         (if_pc),
        .pred_jmp_o    (pred_jmp_o),
        .pred_target_o (pred_target_o),
        .ex_br_valid   (ex_br_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pre_fail   (ex_pre_fail),
        .br_total_o    (br_total_o),
        .br_miss_o     (br_miss_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: 64 slots addressed by word index, tag is the next byte of the PC.
    bit          m_valid  [64];
    int          m_tag    [64];
    logic [31:0] m_target [64];
    int          m_cnt    [64];
    longint      m_total, m_miss;
    int          mi;

    function automatic int pc_idx(logic [31:0] pc);
        return (pc >> 2) % 64;
    endfunction
    function automatic int pc_tag(logic [31:0] pc);
        return (pc >> 8) % 256;
    endfunction
    function automatic bit m_jmp(logic [31:0] pc);
        int ix = pc_idx(pc);
        return m_valid[ix] && (m_tag[ix] == pc_tag(pc)) && (m_cnt[ix] >= 2);
    endfunction
    function automatic logic [31:0] m_tgt(logic [31:0] pc);
        return m_jmp(pc) ? m_target[pc_idx(pc)] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
            end
            m_total = 0;
            m_miss  = 0;
        end else if (rdy && ex_br_valid) begin
            mi = pc_idx(ex_pc);
            if (m_valid[mi] && m_tag[mi] == pc_tag(ex_pc)) begin
                if (ex_taken) begin
                    m_cnt[mi]    = (m_cnt[mi] + 1 > 3) ? 3 : m_cnt[mi] + 1;
                    m_target[mi] = ex_target;
                end else begin
                    m_cnt[mi] = (m_cnt[mi] - 1 < 0) ? 0 : m_cnt[mi] - 1;
                end
            end else if (ex_taken) begin
                m_valid[mi] = 1; m_tag[mi] = pc_tag(ex_pc); m_target[mi] = ex_target; m_cnt[mi] = 2;
            end
            if (m_total < 64'hFFFF_FFFF) m_total++;
            if (ex_pre_fail && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_jmp",    {31'b0, pred_jmp_o}, {31'b0, m_jmp(if_pc)});
            check("model_target", pred_target_o, m_tgt(if_pc));
            check("model_total",  br_total_o, m_total[31:0]);
            check("model_miss",   br_miss_o,  m_miss[31:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(logic [31:0] pc, logic tk, logic [31:0] tgt, logic fail);
        ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_pre_fail = fail; ex_br_valid = 1'b1;
        step();
        ex_br_valid = 1'b0;
    endtask

    task automatic look(string name, logic [31:0] pc, logic exp_jmp, logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({name, "_jmp"}, {31'b0, pred_jmp_o}, {31'b0, exp_jmp});
        check({name, "_tgt"}, pred_target_o, exp_tgt);
    endtask

    task automatic counters(string name, int tot, int miss);
        check({name, "_total"}, br_total_o, tot);
        check({name, "_miss"},  br_miss_o,  miss);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; if_pc = 0;
        ex_br_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pre_fail = 0;
        step(); step();
        rst = 1'b1;
        chk_en = 1'b1;

        look("rst_0", 32'h0, 0, 0);
        look("rst_100", 32'h100, 0, 0);
        look("rst_1fc", 32'h1FC, 0, 0);
        counters("rst", 0, 0);

        resolve(32'h100, 1, 32'h180, 1);
        look("alloc", 32'h100, 1, 32'h180);
        counters("alloc", 1, 1);

        repeat (3) resolve(32'h100, 1, 32'h180, 0);
        look("sat", 32'h100, 1, 32'h180);
        resolve(32'h100, 0, 0, 1);
        look("hyst_nt1", 32'h100, 1, 32'h180);
        resolve(32'h100, 0, 0, 1);
        look("hyst_nt2", 32'h100, 0, 0);
        repeat (2) resolve(32'h100, 0, 0, 0);
        resolve(32'h100, 1, 32'h180, 1);
        look("hyst_floor", 32'h100, 0, 0);
        counters("hyst", 9, 4);

        resolve(32'h100, 1, 32'h180, 0);
        look("retrain", 32'h100, 1, 32'h180);
        resolve(32'h200, 1, 32'h280, 1);
        look("alias_old", 32'h100, 0, 0);
        look("alias_new", 32'h200, 1, 32'h280);
        resolve(32'h100, 0, 0, 0);
        look("alias_nt", 32'h200, 1, 32'h280);
        counters("alias", 12, 5);

        rdy = 1'b0;
        resolve(32'h300, 1, 32'h380, 1);
        rdy = 1'b1;
        look("freeze", 32'h300, 0, 0);
        look("freeze_keep", 32'h200, 1, 32'h280);
        counters("freeze", 12, 5);

        if_pc = 32'h300;
        ex_pc = 32'h300; ex_taken = 1; ex_target = 32'h380; ex_pre_fail = 0; ex_br_valid = 1;
        #1;
        check("collide_pre", {31'b0, pred_jmp_o}, 32'd0);
        step();
        ex_br_valid = 0;
        look("collide_post", 32'h300, 1, 32'h380);
        counters("collide", 13, 5);

        resolve(32'h404, 1, 32'h500, 0);
        resolve(32'h1FC, 1, 32'h40, 1);
        look("train_404", 32'h404, 1, 32'h500);
        look("train_1fc", 32'h1FC, 1, 32'h40);

        rst = 1'b0;
        ex_pc = 32'h808; ex_taken = 1; ex_target = 32'h900; ex_pre_fail = 1; ex_br_valid = 1;
        step();
        rst = 1'b1; ex_br_valid = 0;
        look("mid_rst_300", 32'h300, 0, 0);
        look("mid_rst_404", 32'h404, 0, 0);
        look("mid_rst_1fc", 32'h1FC, 0, 0);
        look("mid_rst_808", 32'h808, 0, 0);
        counters("mid_rst", 0, 0);

        resolve(32'h808, 1, 32'h900, 0);
        look("recover", 32'h808, 1, 32'h900);
        counters("recover", 1, 0);

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch predictor and target buffer for the 5-stage RISC-V pipeline. It answers taken/not-taken and target queries for the PC in IF, which the IF and ID stages carry down the pipeline as the jump flag and offset. It is trained by branch resolutions returned from EX: resolved PC, outcome, target and the `ex_pre_fail` misprediction flag. It also keeps branch and misprediction counters for performance analysis.

## Interface
- `IDX_W`, 6 — index bits; the table has 2^IDX_W entries.
- `TAG_W`, 8 — tag bits stored per entry.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset: synchronous, active-low (rst==0 resets on the rising edge of `clk`).
- `rdy` in 1 — global ready; when 0, all state holds.
- `if_pc` in 32 — PC currently being fetched.
- `pred_jmp_o` out 1 — prediction for `if_pc`: 1 = taken.
- `pred_target_o` out 32 — predicted target. Valid only when `pred_jmp_o`=1; otherwise 0.
- `ex_br_valid` in 1 — EX resolved a conditional branch or JAL this cycle. Asserted for exactly one cycle per instruction. JALR never asserts it.
- `ex_pc` in 32 — PC of the resolved instruction.
- `ex_taken` in 1 — actual outcome.
- `ex_target` in 32 — actual target. Meaningful when `ex_taken`=1.
- `ex_pre_fail` in 1 — EX detected a misprediction. Qualified by `ex_br_valid`.
- `br_total_o` out 32 — count of resolved branches.
- `br_miss_o` out 32 — count of mispredictions.

## Operation
- **Per-entry state:** `valid` (1 bit), `tag` (TAG_W bits), `target` (32 bits), `cnt` (2-bit saturating counter).
- **Index and tag:**
  - index = `pc[IDX_W+1:2]`.
  - tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`.
  - `pc[1:0]` is ignored.
- **Lookup (combinational):** hit = `valid` && tag match on `if_pc`.
  - `pred_jmp_o` = hit && `cnt[1]`.
  - `pred_target_o` = entry `target` when `pred_jmp_o`=1, else 0.
- **Update:** on the rising edge when `rst`=1, `rdy`=1 and `ex_br_valid`=1, at index(`ex_pc`):
  - Hit, `ex_taken`=1: `cnt` = min(`cnt`+1, 3); `target` ← `ex_target`.
  - Hit, `ex_taken`=0: `cnt` = max(`cnt`−1, 0); `target` unchanged.
  - Miss, `ex_taken`=1: allocate or replace the entry. `valid`←1, `tag`←tag(`ex_pc`), `target`←`ex_target`, `cnt`←2.
  - Miss, `ex_taken`=0: no table change.
- **Counters:**
  - `br_total_o` increments on every qualified update.
  - `br_miss_o` increments when `ex_br_valid` && `ex_pre_fail`.
  - Both saturate at 0xFFFFFFFF (no wrap).
- **Reset (`rst`=0 at posedge):**
  - Every entry: `valid`=0, `tag`=0, `target`=0, `cnt`=1.
  - `br_total_o`=0, `br_miss_o`=0.
  - The combinational outputs therefore read `pred_jmp_o`=0 and `pred_target_o`=0 for every PC.
  - Reset has priority over `rdy` and over any update in flight; a resolution presented in the reset cycle is dropped.
- **`rdy`=0:** no table or counter change. Lookup stays combinational on current state.
- **Stalls:** the predictor takes no stall input. Training depends only on the `ex_br_valid` pulse; the producer guarantees one pulse per resolved instruction, including across stalls.

## Timing
- Lookup latency is 0 cycles: combinational from `if_pc` and registered table state.
- Update latency is 1 cycle: a resolution at edge N is visible to lookups in cycle N+1.
- **Same-index collision:** if `if_pc` and `ex_pc` map to the same index in one cycle, the lookup returns the pre-update value. There is no write-through bypass.
- **Aliasing:** two PCs with equal index and different tags evict each other on taken resolutions. A not-taken miss leaves the resident entry intact.
- `br_total_o` and `br_miss_o` are registered; an increment appears the cycle after the qualifying edge.
- Table storage is a register array so reset can clear it in one cycle; no RAM macro is used.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles, release. Sweep `if_pc` over 0x0, 0x100, 0x1FC → `pred_jmp_o`=0, `pred_target_o`=0, both counters 0.
- **Allocate:** `ex_br_valid`=1, `ex_pc`=0x100, `ex_taken`=1, `ex_target`=0x180, `ex_pre_fail`=1 → next cycle, `if_pc`=0x100 gives `pred_jmp_o`=1 and `pred_target_o`=0x180; `br_total_o`=1, `br_miss_o`=1.
- **Saturation and hysteresis:** continuing from the previous scenario with `cnt` at 2, apply three more taken updates (`cnt` saturates at 3). Then one not-taken → still predicts taken; a second not-taken → `pred_jmp_o`=0. Two further not-taken updates leave `cnt`=0; a single taken update then still predicts not-taken.
- **Aliasing:** train 0x100 taken → 0x180, then 0x200 taken → 0x280 (same index 0, tags 1 vs 2) → 0x100 now misses with `pred_jmp_o`=0, and 0x200 predicts 0x280. A not-taken resolution of 0x100 leaves 0x200's prediction unchanged.
- **Freeze and collision:** with `rdy`=0, pulse a taken update for 0x300 → no effect, counters unchanged. With `rdy`=1, `if_pc`=`ex_pc`=0x300 taken in the same cycle → that cycle predicts not-taken, the next cycle predicts taken.
- **Reset mid-operation:** after training several entries, assert `rst`=0 together with `ex_br_valid`=1 → all predictions return to 0, counters return to 0, and the concurrent update is dropped.
